instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for each core. It holds the architectural fetch PC, issues 16-bit instruction reads to instruction memory over a request/grant/response handshake, and presents each fetched instruction with its PC to decode over a valid/ready handshake. It consumes the PC updater's output (`pc_new`) as a redirect target when a branch is taken, and otherwise advances sequentially by 2. One instance per core.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bit 0 is ignored and treated as 0.
- `INSTR_W`, default 16: instruction width in bits.

- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc_new`  in  32  redirect target from the PC updater (PC+Imm)
- `pc_load`  in  1  redirect strobe (the PC updater's CTRL, qualified by a taken branch); one-cycle pulse
- `imem_req`  out  1  instruction read request
- `imem_addr`  out  32  read address; equals the current fetch PC
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid; exactly one per grant, at least 1 cycle after the grant
- `imem_rdata`  in  INSTR_W  read data
- `if_valid`  out  1  instruction available to decode
- `if_instr`  out  INSTR_W  fetched instruction
- `if_pc`  out  32  address of `if_instr`
- `if_ready`  in  1  decode accepts the instruction this cycle

## Operation
- Internal `pc` register, 32 bits. Sequential advance is `pc + 2`, modulo 2^32, so 32'hFFFF_FFFE wraps to 0. Loaded values always have bit 0 forced to 0.
- The FSM has five states: IDLE, REQ, WAIT, HOLD, DROP.
  - **IDLE.** Entered on reset. Outputs are quiet. Goes to REQ on the next cycle.
  - **REQ.** `imem_req`=1 and `imem_addr`=`pc`. On `imem_gnt`, go to WAIT. Otherwise stay in REQ. The address is held stable unless a redirect occurs.
  - **WAIT.** On `imem_rvalid`, capture `if_instr`←`imem_rdata`, `if_pc`←`pc`, `if_valid`←1, `pc`←`pc+2`, then go to HOLD.
  - **HOLD.** `if_valid`=1. On `if_ready`, clear `if_valid` and go to REQ.
  - **DROP.** Waits for the response to an abandoned request. On `imem_rvalid`, discard the data and go to REQ.
- A redirect (`pc_load`=1) sets `pc`←{`pc_new`[31:1],1'b0} in every state. This has priority over the sequential advance. State handling:
  - **IDLE:** go to REQ as normal.
  - **REQ without gnt:** stay in REQ. The next cycle shows the new address. Memory samples the address only on the grant cycle.
  - **REQ with gnt in the same cycle, or WAIT without rvalid:** go to DROP.
  - **WAIT with rvalid in the same cycle:** discard the data, keep `if_valid`=0, go to REQ.
  - **HOLD:** clear `if_valid` even if `if_ready`=1 in the same cycle, then go to REQ. Decode must ignore an instruction that is accepted in a redirect cycle.
  - **DROP:** update `pc` and stay in DROP.
- Only one memory request is ever outstanding.
- A `imem_rvalid` arriving in IDLE, REQ or HOLD is ignored.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE
  - `pc`=`RESET_PC` with bit 0 cleared
  - `imem_req`=0
  - `if_valid`=0
  - `if_instr`=0
  - `if_pc`=0
- `imem_req` and `imem_addr` are decoded from the registered state and `pc`. `if_*` outputs are registered.
- Best case, with gnt in the first REQ cycle, rvalid 1 cycle later, and ready asserted immediately:
  - first REQ is in cycle 1 after reset release
  - `if_valid` rises at the end of cycle 2
  - throughput is 1 instruction per 3 cycles
- Redirect to first request at the new address: 1 cycle, or after the pending rvalid if in DROP.
- A reset assertion mid-transaction aborts immediately. Any in-flight response after reset release is the memory's responsibility; the memory is reset by the same `rst_n`.

## Test plan
- **Reset fetch.** `RESET_PC`=0x100, gnt tied 1, rvalid 1 cycle after gnt, ready=1 → addresses 0x100, 0x102, 0x104; `if_pc` matches; `if_instr` equals the memory image.
- **Backpressure.** `if_ready`=0 for 5 cycles in HOLD → `if_valid`, `if_instr` and `if_pc` are held stable, no new `imem_req`, `pc` is already 0x102.
- **Redirect in WAIT.** `pc_load` with `pc_new`=0x200 while a fetch of 0x104 is outstanding → enters DROP, the 0x104 data never appears on `if_*`, next request address is 0x200.
- **Redirect in HOLD with ready.** `pc_load`, `pc_new`=0x254 (+1 offset gives 0x255) in the same cycle as `if_ready` → `if_valid` drops, next request address is 0x254.
- **Wrap-around.** `pc_load`, `pc_new`=0xFFFF_FFFE → fetches 0xFFFF_FFFE, then 0x0000_0000.
- **Grant stall and async reset.** gnt withheld 4 cycles → `imem_addr` stable throughout. Assert `rst_n`=0 mid-WAIT → all outputs reset values immediately, `pc`=`RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the fetch PC, issues one outstanding imem read at a time,
// and presents each fetched instruction with its PC to decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc_new,
    input  logic               pc_load,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    input  logic               if_ready
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        take;
    // a response is kept only when no redirect lands in the same cycle
    assign take      = state == WAIT && imem_rvalid && !pc_load;
    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    always_comb begin
        state_nx = state;
        pc_nx    = pc_load ? (pc_new & 32'hFFFF_FFFE) : take ? pc + 32'd2 : pc;
        case (state)
            IDLE:    state_nx = REQ;
            REQ:     state_nx = imem_gnt ? (pc_load ? DROP : WAIT) : REQ;
            WAIT:    state_nx = imem_rvalid ? (pc_load ? REQ : HOLD) : (pc_load ? DROP : WAIT);
            HOLD:    state_nx = (if_ready || pc_load) ? REQ : HOLD;
            DROP:    state_nx = imem_rvalid ? REQ : DROP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC & 32'hFFFF_FFFE;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            if_valid <= take || (if_valid && !if_ready && !pc_load);
            if (take) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test-plan scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the fetch stage and its memory.
module tb_instr_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_new;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    instr_fetch_unit #(.RESET_PC(RPC), .INSTR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_new(pc_new), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit chk_en = 0;
    int lat = 0;

    // model: fetch pc, whether a read is in flight, whether it was abandoned,
    // whether an instruction is being offered, plus the memory's pending response
    bit          started, busy, stale, have;
    logic [31:0] m_pc, m_ip, mem_addr;
    logic [15:0] m_ins;
    int          mem_cnt;

    function automatic logic [15:0] img(logic [31:0] a);
        return a[16:1] ^ {a[8:1], a[31:24]} ^ 16'hC35A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        started = 0; busy = 0; stale = 0; have = 0;
        m_pc = RPC & 32'hFFFF_FFFE; m_ip = 0; m_ins = 0; mem_addr = 0; mem_cnt = 0;
    endtask

    task automatic model_update();
        bit req, ld;
        req = started && !busy && !have;
        ld  = pc_load;
        if (have && (if_ready || ld)) have = 0;
        if (busy) begin
            if (imem_rvalid) begin
                busy = 0;
                if (!stale && !ld) begin
                    have = 1; m_ip = m_pc; m_ins = imem_rdata; m_pc = m_pc + 32'd2;
                end
                stale = 0;
            end else begin
                stale = stale || ld;
                if (mem_cnt > 0) mem_cnt--;
            end
        end else if (req && imem_gnt) begin
            busy = 1; stale = ld; mem_addr = m_pc; mem_cnt = int'($urandom_range(lat, 0));
        end
        if (ld) m_pc = pc_new & 32'hFFFF_FFFE;
        started = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic setin(bit g, bit rdy, bit ld, logic [31:0] nw);
        imem_gnt    = g;
        if_ready    = rdy;
        pc_load     = ld;
        pc_new      = nw;
        imem_rvalid = busy && mem_cnt == 0;
        imem_rdata  = busy ? img(mem_addr) : 16'h0;
    endtask

    task automatic rnd();
        imem_gnt    = $urandom_range(99) < 60;
        if_ready    = $urandom_range(99) < 60;
        pc_load     = $urandom_range(99) < 7;
        pc_new      = ($urandom_range(99) < 20) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        imem_rvalid = busy ? (mem_cnt == 0) : ($urandom_range(99) < 10);
        imem_rdata  = busy ? img(mem_addr) : 16'($urandom);
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("req", 32'(imem_req), 32'(started && !busy && !have));
        if (started && !busy && !have) chk("addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(have));
        chk("if_pc", if_pc, m_ip);
        chk("if_instr", 32'(if_instr), 32'(m_ins));
    end

    initial begin
        rst_n = 0;
        setin(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(if_valid), 0);
        rst_n = 1;
        // reset fetch with gnt tied high and 1-cycle latency
        setin(1, 1, 0, 0);
        chk("idle_req", 32'(imem_req), 0);
        tick(); chk("f0_addr", imem_addr, 32'h100); chk("f0_req", 32'(imem_req), 1);
        setin(1, 1, 0, 0); tick(); chk("wait_req", 32'(imem_req), 0);
        setin(1, 1, 0, 0); tick();
        chk("f0_valid", 32'(if_valid), 1); chk("f0_pc", if_pc, 32'h100);
        chk("f0_instr", 32'(if_instr), 32'(img(32'h100)));
        setin(1, 1, 0, 0); tick(); chk("f1_addr", imem_addr, 32'h102);
        setin(1, 1, 0, 0); tick();
        setin(1, 1, 0, 0); tick(); chk("f1_pc", if_pc, 32'h102);
        setin(1, 1, 0, 0); tick(); chk("f2_addr", imem_addr, 32'h104);
        // backpressure in HOLD
        setin(1, 0, 0, 0); tick();
        setin(1, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(if_valid), 1); chk("bp_pc", if_pc, 32'h104);
            chk("bp_req", 32'(imem_req), 0);
            setin(1, 0, 0, 0); tick();
        end
        // redirect in HOLD coinciding with ready, odd target
        setin(1, 1, 1, 32'h255); tick();
        chk("rh_valid", 32'(if_valid), 0); chk("rh_addr", imem_addr, 32'h254);
        // redirect while the fetch is outstanding
        setin(1, 1, 0, 0); tick();
        setin(1, 1, 1, 32'h200); imem_rvalid = 0; tick();
        chk("rw_req", 32'(imem_req), 0);
        setin(1, 1, 0, 0); tick();
        chk("rw_addr", imem_addr, 32'h200); chk("rw_valid", 32'(if_valid), 0);
        chk("rw_pc", if_pc, 32'h104);
        // wrap-around
        setin(0, 1, 1, 32'hFFFF_FFFF); tick(); chk("wr_addr", imem_addr, 32'hFFFF_FFFE);
        setin(1, 1, 0, 0); tick();
        setin(1, 1, 0, 0); tick(); chk("wr_pc", if_pc, 32'hFFFF_FFFE);
        setin(1, 1, 0, 0); tick(); chk("wr_next", imem_addr, 32'h0);
        // grant stall, then async reset in WAIT
        for (int i = 0; i < 4; i++) begin
            setin(0, 1, 0, 0); tick();
            chk("st_req", 32'(imem_req), 1); chk("st_addr", imem_addr, 32'h0);
        end
        setin(1, 1, 0, 0); tick();
        setin(0, 1, 0, 0); imem_rvalid = 0;
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("ar_req", 32'(imem_req), 0); chk("ar_valid", 32'(if_valid), 0);
        chk("ar_instr", 32'(if_instr), 0); chk("ar_pc", if_pc, 0);
        @(negedge clk);
        rst_n = 1;
        setin(0, 1, 0, 0); tick();
        setin(0, 1, 0, 0); tick();
        chk("ar_addr", imem_addr, 32'h100);
        // randomized traffic
        lat = 3;
        repeat (3000) begin
            rnd();
            tick();
        end
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
